// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 set-2 scan-code decoder.
//   state_e     : decoder FSM state (IDLE, EXT, BRK)
//   BYTE_*      : special scan bytes (extended prefix, break prefix, null)
//   ps2_event_t : one decoded key action {ext, brk, code}
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        BRK  = 2'd2
    } state_e;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_NUL = 8'h00;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through synchronous FIFO.
//   clk, reset (sync, active-low)
//   push, push_data : write request and data; ignored when full unless a pop
//                     happens on the same edge
//   pop             : consume head entry; ignored when empty
//   head_data       : current head entry (valid when valid=1)
//   valid           : FIFO non-empty
//   full            : FIFO holds DEPTH entries
//   level           : number of entries held
// Pointers carry one extra MSB so that full and empty are distinguishable
// when the index bits are equal.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level     = wr_ptr - rd_ptr;
    assign valid     = (level != '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign do_pop    = pop && valid;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 set-2 scan-code decoder with event FIFO.
//   clk, reset (sync, active-low)
//   in_valid, in_byte      : one received scan byte per strobe, no back-pressure
//   out_valid, out_ready   : event handshake; the head event is consumed on an
//                            edge where out_valid && out_ready, and the head
//                            fields stay stable while out_valid && !out_ready
//   out_ext, out_brk, out_code : head event; hold last value while empty
//   fifo_level             : events queued
//   drop_cnt               : events lost to a full FIFO (saturating)
//   err_cnt                : protocol errors plus prefix timeouts (saturating)
//   state                  : decoder FSM state, debug visibility
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1_000_000,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_ext,
    output logic                          out_brk,
    output logic [7:0]                    out_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [1:0]                    state
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e      st, nxt_st;
    logic        ext_q, nxt_ext;
    logic [TW-1:0] tmo_cnt, nxt_tmo;
    logic        byte_ok;
    logic        emit;
    ps2_event_t  evt;
    logic        proto_err;
    logic        tmo_fire;
    logic        drop;
    logic        fifo_full;
    logic        fifo_valid;
    ps2_event_t  head;
    ps2_event_t  last_evt;

    assign byte_ok = in_valid && (in_byte != BYTE_NUL);
    assign state   = st;

    always_comb begin
        nxt_st    = st;
        nxt_ext   = ext_q;
        emit      = 1'b0;
        evt       = '0;
        proto_err = 1'b0;
        tmo_fire  = 1'b0;
        nxt_tmo   = tmo_cnt;

        if (byte_ok) begin
            case (st)
                IDLE: begin
                    if (in_byte == BYTE_EXT) begin
                        nxt_st = EXT;
                    end else if (in_byte == BYTE_BRK) begin
                        nxt_st  = BRK;
                        nxt_ext = 1'b0;
                    end else begin
                        emit = 1'b1;
                        evt  = '{ext: 1'b0, brk: 1'b0, code: in_byte};
                    end
                end
                EXT: begin
                    if (in_byte == BYTE_BRK) begin
                        nxt_st  = BRK;
                        nxt_ext = 1'b1;
                    end else if (in_byte != BYTE_EXT) begin
                        emit   = 1'b1;
                        evt    = '{ext: 1'b1, brk: 1'b0, code: in_byte};
                        nxt_st = IDLE;
                    end
                end
                BRK: begin
                    // A prefix where a key code belongs is consumed, not replayed.
                    if (in_byte == BYTE_EXT || in_byte == BYTE_BRK) begin
                        proto_err = 1'b1;
                    end else begin
                        emit = 1'b1;
                        evt  = '{ext: ext_q, brk: 1'b1, code: in_byte};
                    end
                    nxt_st = IDLE;
                end
                default: nxt_st = IDLE;
            endcase
        end else if (TIMEOUT != 0 && st != IDLE) begin
            // The counter holds TIMEOUT-1 on the edge where it reaches TIMEOUT.
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                tmo_fire = 1'b1;
                nxt_st   = IDLE;
            end
        end

        if (TIMEOUT == 0 || byte_ok || nxt_st == IDLE) begin
            nxt_tmo = '0;
        end else begin
            nxt_tmo = tmo_cnt + 1'b1;
        end
    end

    // When full, out_valid is 1, so out_ready alone tells whether a pop frees a slot.
    assign drop = emit && fifo_full && !out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st       <= IDLE;
            ext_q    <= 1'b0;
            tmo_cnt  <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
            last_evt <= '0;
        end else begin
            st      <= nxt_st;
            ext_q   <= nxt_ext;
            tmo_cnt <= nxt_tmo;
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if ((proto_err || tmo_fire) && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (fifo_valid) begin
                last_evt <= head;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ps2_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emit),
        .push_data (evt),
        .pop       (out_ready),
        .head_data (head),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Storage beyond the read pointer is stale after the last pop, so the
    // visible fields fall back to the last head seen.
    assign out_valid = fifo_valid;
    assign out_ext   = fifo_valid ? head.ext  : last_evt.ext;
    assign out_brk   = fifo_valid ? head.brk  : last_evt.brk;
    assign out_code  = fifo_valid ? head.code : last_evt.code;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed scenarios plus randomized traffic checked
// against a sequence-level reference model of the scan-code protocol.
module tb_ps2_scancode_decoder;
    import ps2_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TMO     = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        out_ready = 1'b0;
    logic        out_valid, out_ext, out_brk;
    logic [7:0]  out_code;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0] drop_cnt, err_cnt;
    logic [1:0]  state;

    ps2_scancode_decoder #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ext    (out_ext),
        .out_brk    (out_brk),
        .out_code   (out_code),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending prefix bytes, idle cycles, event queue, counters.
    logic [7:0] m_seq[$];
    logic [9:0] exp_q[$];
    logic [9:0] last_head = '0;
    int         m_idle = 0;
    int         m_drop = 0;
    int         m_err  = 0;

    function automatic logic [9:0] dut_head();
        return {out_ext, out_brk, out_code};
    endfunction

    function automatic logic [9:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : last_head;
    endfunction

    task automatic model_clear();
        m_seq.delete();
        exp_q.delete();
        last_head = '0;
        m_idle = 0;
        m_drop = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit r);
        bit pop_now;
        bit have_ev;
        bit has_e0, has_f0;
        logic [9:0] ev;
        pop_now = r && (exp_q.size() > 0);
        have_ev = 1'b0;
        ev = '0;
        if (v && b != 8'h00) begin
            m_idle = 0;
            if (m_seq.size() > 0 && m_seq[$] == 8'hF0 && (b == 8'hE0 || b == 8'hF0)) begin
                if (m_err < CNT_MAX) m_err++;
                m_seq.delete();
            end else if (b == 8'hE0 || b == 8'hF0) begin
                // Repeated E0 collapses into one pending prefix.
                if (!(b == 8'hE0 && m_seq.size() > 0 && m_seq[$] == 8'hE0)) m_seq.push_back(b);
            end else begin
                has_e0 = 0;
                has_f0 = 0;
                foreach (m_seq[i]) begin
                    if (m_seq[i] == 8'hE0) has_e0 = 1;
                    if (m_seq[i] == 8'hF0) has_f0 = 1;
                end
                ev = {has_e0, has_f0, b};
                have_ev = 1'b1;
                m_seq.delete();
            end
        end else if (m_seq.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_seq.delete();
                m_idle = 0;
                if (m_err < CNT_MAX) m_err++;
            end
        end
        if (pop_now) void'(exp_q.pop_front());
        if (have_ev) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ev);
            else if (m_drop < CNT_MAX) m_drop++;
        end
        if (exp_q.size() > 0) last_head = exp_q[0];
    endtask

    // Drive one cycle from a negedge; returns at the following negedge.
    task automatic drive_cycle(input bit v, input logic [7:0] b, input bit r);
        in_valid  = v;
        in_byte   = b;
        out_ready = r;
        @(posedge clk);
        model_step(v, b, r);
        @(negedge clk);
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (dut_head() !== 10'h000) begin n_fail++; $display("FAIL reset_head: got %h want 000", dut_head()); end
        n_cmp++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (drop_cnt !== '0 || err_cnt !== '0) begin n_fail++; $display("FAIL reset_cnts: got drop %0d err %0d want 0 0", drop_cnt, err_cnt); end
        n_cmp++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    endtask

    task automatic test_make_break();
        drive_cycle(1, 8'h1C, 1);
        n_cmp++; if (out_valid !== 1'b1 || dut_head() !== {2'b00, 8'h1C}) begin n_fail++; $display("FAIL make_1c: got v=%b %h want v=1 %h", out_valid, dut_head(), {2'b00, 8'h1C}); end
        drive_cycle(1, 8'hF0, 1);
        n_cmp++; if (out_valid !== 1'b0 || fifo_level !== '0) begin n_fail++; $display("FAIL make_popped: got v=%b lvl=%0d want v=0 lvl=0", out_valid, fifo_level); end
        drive_cycle(1, 8'h1C, 1);
        n_cmp++; if (out_valid !== 1'b1 || dut_head() !== {2'b01, 8'h1C}) begin n_fail++; $display("FAIL break_1c: got v=%b %h want v=1 %h", out_valid, dut_head(), {2'b01, 8'h1C}); end
        drive_cycle(0, 8'h00, 1);
        n_cmp++; if (out_valid !== 1'b0 || dut_head() !== {2'b01, 8'h1C} || err_cnt !== '0) begin n_fail++; $display("FAIL break_hold: got v=%b %h err=%0d want v=0 %h err=0", out_valid, dut_head(), err_cnt, {2'b01, 8'h1C}); end
    endtask

    task automatic test_ext();
        logic [7:0] seq [8];
        seq = '{8'hE0, 8'h00, 8'h75, 8'h00, 8'hE0, 8'hF0, 8'h00, 8'h75};
        foreach (seq[i]) drive_cycle(1, seq[i], 0);
        n_cmp++; if (fifo_level !== 2 || dut_head() !== {2'b10, 8'h75}) begin n_fail++; $display("FAIL ext_make: got lvl=%0d %h want lvl=2 %h", fifo_level, dut_head(), {2'b10, 8'h75}); end
        drive_cycle(0, 8'h00, 1);
        n_cmp++; if (out_valid !== 1'b1 || dut_head() !== {2'b11, 8'h75}) begin n_fail++; $display("FAIL ext_break: got v=%b %h want v=1 %h", out_valid, dut_head(), {2'b11, 8'h75}); end
        drive_cycle(0, 8'h00, 1);
        n_cmp++; if (out_valid !== 1'b0 || err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL ext_drain: got v=%b err=%0d want v=0 err=%0d", out_valid, err_cnt, m_err); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [7];
        do_reset();
        foreach (codes[i]) codes[i] = 8'($urandom_range(1, 8'hDF));
        for (int i = 0; i < 6; i++) drive_cycle(1, codes[i], 0);
        n_cmp++; if (fifo_level !== DEPTH || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_full: got lvl=%0d drop=%0d want lvl=%0d drop=2", fifo_level, drop_cnt, DEPTH); end
        n_cmp++; if (dut_head() !== {2'b00, codes[0]}) begin n_fail++; $display("FAIL ovf_head: got %h want %h", dut_head(), {2'b00, codes[0]}); end
        drive_cycle(1, codes[6], 1);
        n_cmp++; if (fifo_level !== DEPTH || drop_cnt !== 8'd2 || dut_head() !== {2'b00, codes[1]}) begin n_fail++; $display("FAIL ovf_pushpop: got lvl=%0d drop=%0d %h want lvl=%0d drop=2 %h", fifo_level, drop_cnt, dut_head(), DEPTH, {2'b00, codes[1]}); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (dut_head() !== exp_head()) begin n_fail++; $display("FAIL ovf_order: got %h want %h", dut_head(), exp_head()); end
            drive_cycle(0, 8'h00, 1);
        end
        n_cmp++; if (out_valid !== 1'b0 || fifo_level !== '0) begin n_fail++; $display("FAIL ovf_empty: got v=%b lvl=%0d want 0 0", out_valid, fifo_level); end
    endtask

    task automatic test_timeout();
        int err0;
        err0 = m_err;
        drive_cycle(1, 8'hE0, 0);
        for (int i = 0; i < TMO - 1; i++) drive_cycle(i % 4 == 0, 8'h00, 0);
        n_cmp++; if (state !== EXT || err_cnt !== 8'(err0)) begin n_fail++; $display("FAIL tmo_before: got st=%0d err=%0d want st=%0d err=%0d", state, err_cnt, EXT, err0); end
        drive_cycle(0, 8'h00, 0);
        n_cmp++; if (state !== IDLE || err_cnt !== 8'(err0 + 1) || out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: got st=%0d err=%0d v=%b want st=0 err=%0d v=0", state, err_cnt, out_valid, err0 + 1); end
        drive_cycle(1, 8'h1C, 0);
        n_cmp++; if (dut_head() !== {2'b00, 8'h1C} || fifo_level !== 1) begin n_fail++; $display("FAIL tmo_next: got %h lvl=%0d want %h lvl=1", dut_head(), fifo_level, {2'b00, 8'h1C}); end
        drive_cycle(0, 8'h00, 1);
        // A repeated E0 restarts the idle count.
        drive_cycle(1, 8'hE0, 0);
        repeat (10) drive_cycle(0, 8'h00, 0);
        drive_cycle(1, 8'hE0, 0);
        repeat (10) drive_cycle(0, 8'h00, 0);
        n_cmp++; if (state !== EXT || err_cnt !== 8'(err0 + 1)) begin n_fail++; $display("FAIL tmo_restart: got st=%0d err=%0d want st=%0d err=%0d", state, err_cnt, EXT, err0 + 1); end
        repeat (6) drive_cycle(0, 8'h00, 0);
        n_cmp++; if (state !== IDLE || err_cnt !== 8'(err0 + 2)) begin n_fail++; $display("FAIL tmo_brk: got st=%0d err=%0d want st=0 err=%0d", state, err_cnt, err0 + 2); end
    endtask

    task automatic test_proto_err();
        int err0;
        err0 = m_err;
        drive_cycle(1, 8'hF0, 0);
        drive_cycle(1, 8'hE0, 0);
        n_cmp++; if (err_cnt !== 8'(err0 + 1) || out_valid !== 1'b0 || state !== IDLE) begin n_fail++; $display("FAIL perr_f0e0: got err=%0d v=%b st=%0d want err=%0d v=0 st=0", err_cnt, out_valid, state, err0 + 1); end
        drive_cycle(1, 8'h29, 0);
        n_cmp++; if (dut_head() !== {2'b00, 8'h29}) begin n_fail++; $display("FAIL perr_next: got %h want %h", dut_head(), {2'b00, 8'h29}); end
        drive_cycle(1, 8'hE0, 1);
        drive_cycle(1, 8'hF0, 0);
        drive_cycle(1, 8'hF0, 0);
        drive_cycle(1, 8'h29, 0);
        n_cmp++; if (err_cnt !== 8'(err0 + 2) || dut_head() !== {2'b00, 8'h29} || fifo_level !== 1) begin n_fail++; $display("FAIL perr_e0f0f0: got err=%0d %h lvl=%0d want err=%0d %h lvl=1", err_cnt, dut_head(), fifo_level, err0 + 2, {2'b00, 8'h29}); end
        drive_cycle(0, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 8'h16, 0);
        drive_cycle(1, 8'h1E, 0);
        drive_cycle(1, 8'h26, 0);
        drive_cycle(1, 8'hF0, 0);
        do_reset();
        n_cmp++; if (out_valid !== 1'b0 || fifo_level !== '0 || drop_cnt !== '0 || err_cnt !== '0) begin n_fail++; $display("FAIL rstmid_clear: got v=%b lvl=%0d drop=%0d err=%0d want all 0", out_valid, fifo_level, drop_cnt, err_cnt); end
        drive_cycle(1, 8'h29, 0);
        n_cmp++; if (dut_head() !== {2'b00, 8'h29} || fifo_level !== 1) begin n_fail++; $display("FAIL rstmid_make: got %h lvl=%0d want %h lvl=1", dut_head(), fifo_level, {2'b00, 8'h29}); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            drive_cycle(1, 8'hF0, 0);
            drive_cycle(1, 8'hE0, 0);
        end
        n_cmp++; if (err_cnt !== 8'(CNT_MAX)) begin n_fail++; $display("FAIL sat_err: got %0d want %0d", err_cnt, CNT_MAX); end
        for (int i = 0; i < CNT_MAX + DEPTH + 4; i++) drive_cycle(1, 8'h34, 0);
        n_cmp++; if (drop_cnt !== 8'(CNT_MAX) || fifo_level !== DEPTH) begin n_fail++; $display("FAIL sat_drop: got drop=%0d lvl=%0d want %0d %0d", drop_cnt, fifo_level, CNT_MAX, DEPTH); end
    endtask

    task automatic test_random();
        int sel;
        bit v;
        logic [7:0] b;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Alternate dense bursts with sparse stretches that let prefixes time out.
            v = ((cyc / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 8'h00;
            else if (sel <= 2) b = 8'hE0;
            else if (sel <= 4) b = 8'hF0;
            else               b = 8'($urandom_range(1, 8'hDF));
            drive_cycle(v, b, $urandom_range(0, 2) == 0);
            n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_valid, exp_q.size() > 0); end
            n_cmp++; if (dut_head() !== exp_head()) begin n_fail++; $display("FAIL rnd_head cyc %0d: got %h want %h", cyc, dut_head(), exp_head()); end
            n_cmp++; if (fifo_level !== exp_q.size()) begin n_fail++; $display("FAIL rnd_level cyc %0d: got %0d want %0d", cyc, fifo_level, exp_q.size()); end
            n_cmp++; if (drop_cnt !== 8'(m_drop) || err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL rnd_cnts cyc %0d: got drop=%0d err=%0d want %0d %0d", cyc, drop_cnt, err_cnt, m_drop, m_err); end
            n_cmp++; if ((state == IDLE) !== (m_seq.size() == 0)) begin n_fail++; $display("FAIL rnd_state cyc %0d: got st=%0d want idle=%b", cyc, state, m_seq.size() == 0); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_make_break();
        test_ext();
        test_overflow();
        test_timeout();
        test_proto_err();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Parametrised PS/2 set-2 scan-code decoder; successor to the single-byte keyboard FSM. Consumes the byte stream from the PS/2 receiver, a byte-valid strobe per received byte. Recognises make, break, extended (E0) make and extended break sequences, and queues one decoded event per key action in an internal FIFO drained with a valid/ready handshake. Adds prefix timeout, protocol-error detection, and saturating overflow/error counters for the debug register file.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2
- TIMEOUT, 1_000_000, idle cycles allowed between a prefix byte and its completion; 0 disables the timeout
- CNT_W, 8, width of the drop and error counters
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low; `reset==0` at a rising edge clears all state
- in_valid  in  1  one-cycle strobe: in_byte holds a received byte
- in_byte  in  8  received scan byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head event when `out_valid && out_ready`
- out_ext  out  1  head event carried an E0 prefix
- out_brk  out  1  head event is a release (F0)
- out_code  out  8  head event key code
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- drop_cnt  out  CNT_W  events lost to a full FIFO; saturating
- err_cnt  out  CNT_W  protocol errors plus timeouts; saturating

## Operation
- Reset values: state IDLE, FIFO empty, out_valid=0, out_ext=0, out_brk=0, out_code=0, fifo_level=0, drop_cnt=0, err_cnt=0, timeout counter 0.
- Bytes are processed only when in_valid=1. Byte 00 is ignored in every state and does not reset the timeout counter.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK with ext=0.
  - Any other byte: emit {ext=0, brk=0, code}; stay in IDLE.
- EXT:
  - F0 -> BRK with ext=1.
  - E0 -> stay in EXT; the timeout counter restarts.
  - Any other byte: emit {1, 0, code} -> IDLE.
- BRK:
  - E0 or F0: protocol error, err_cnt+1, -> IDLE. The byte is consumed and is not re-interpreted.
  - Any other byte: emit {ext, 1, code} -> IDLE.
- Timeout:
  - In EXT or BRK, a counter increments on every cycle without a valid non-00 byte.
  - On reaching TIMEOUT: -> IDLE, err_cnt+1, no event emitted.
  - The counter clears on entry to IDLE and on every accepted non-00 byte.
- Emit pushes a 10-bit entry {ext, brk, code} into the FIFO:
  - If the FIFO is full and no pop occurs in the same cycle, the event is dropped and drop_cnt+1.
  - If full and a pop occurs in the same cycle, the push is accepted and the level stays at FIFO_DEPTH.
- Counters stick at 2^CNT_W-1.
- Reset asserted mid-sequence or with a non-empty FIFO discards everything; no partial event survives.

## Timing
- Byte to output latency is 1 cycle. A terminating byte with in_valid at edge n gives out_valid=1 and the data after edge n, when the FIFO was empty. The FIFO is first-word fall-through.
- out_ext, out_brk and out_code are stable while out_valid=1 and out_ready=0. Their values are don't-care when out_valid=0, but they hold their last value.
- A pop at edge n exposes the next entry, or out_valid=0, after edge n.
- fifo_level updates on the same edge as push or pop. Simultaneous push and pop with level L between 1 and DEPTH leaves the level at L. With L=0, the push lands and the level becomes 1; no pop is possible at empty.
- The decoder accepts one byte per cycle with no back-pressure. A full FIFO never stalls input; excess events are dropped.
- The timeout fires on the cycle the counter equals TIMEOUT. The transition to IDLE is visible after that edge.

## Structure
- Package `ps2_pkg`:
  - State enum {IDLE, EXT, BRK}.
  - Constants BYTE_EXT=8'hE0, BYTE_BRK=8'hF0, BYTE_NUL=8'h00.
  - Packed event struct {ext, brk, code[7:0]}.
- Sub-module `sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, push_data, pop, head_data, valid, full, level.
  - First-word fall-through, pointer wrap-around with an extra MSB for the full/empty distinction.
  - Reusable by other peripherals.
- The top level contains only the decode FSM, the timeout counter and the saturating counters.

## Test plan
- Reset then bytes 1C, F0, 1C with out_ready=1 -> events {0,0,1C} then {0,1,1C}; err_cnt=0.
- Bytes E0, 75, E0, F0, 75 -> events {1,0,75} and {1,1,75}; interleaved 00 bytes change nothing.
- out_ready=0, FIFO_DEPTH=4, six make codes -> fifo_level=4, drop_cnt=2, head equals the first code. Then one pop on the same cycle as a push -> level stays 4, drop_cnt stays 2.
- TIMEOUT=16: E0 followed by 16 idle cycles -> state IDLE, err_cnt=1, no event. The next byte 1C -> {0,0,1C}.
- F0 then E0 -> err_cnt+1, no event. The next byte 29 -> {0,0,29}.
- Reset (reset=0) asserted after F0 with 3 queued events -> out_valid=0, level 0, counters 0. A following 29 is decoded as make {0,0,29}.
